// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_tx
// Description : Parallel-in, serial-out shift transmitter. Accepts a WIDTH-bit
//               word over valid/ready and shifts it out one bit per i_ce
//               strobe, with first/last bit markers. Words can stream
//               back-to-back with no idle bit between them.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_tx #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             i_ce,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_serial,
   output logic             o_bit_valid,
   output logic             o_first,
   output logic             o_last
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [0:0]    c_IDLE  = 1'b0;
   localparam logic [0:0]    c_SHIFT = 1'b1;
   localparam logic [CW-1:0] c_LAST  = CW'(WIDTH - 1);
   localparam logic [CW-1:0] c_ONE   = CW'(1);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_sh;
   logic [CW-1:0]    r_cnt;

   logic             w_shifting;
   logic             w_at_last;
   logic             w_ready;
   logic             w_accept;
   logic [WIDTH-1:0] w_sh_next;
   logic             w_out_bit;

   // Bit order only changes which end of the register drives the line and
   // which direction the register moves.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_sh_next = {r_sh[WIDTH-2:0], 1'b0};
         assign w_out_bit = r_sh[WIDTH-1];
      end else begin : g_lsb_first
         assign w_sh_next = {1'b0, r_sh[WIDTH-1:1]};
         assign w_out_bit = r_sh[0];
      end
   endgenerate

   // Handshake: ready in IDLE, or on the strobe that retires the last bit so
   // the next word follows without a gap. i_valid never feeds o_ready.
   always_comb begin
      w_shifting = (r_state == c_SHIFT);
      w_at_last  = (r_cnt == c_LAST);
      w_ready    = (r_state == c_IDLE) | (w_shifting & w_at_last & i_ce);
      w_accept   = i_valid & w_ready;
   end

   // Frame sequencer: load on accept, shift on strobe, reload or idle after
   // the last bit. Reset aborts any frame in progress.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= c_IDLE;
         r_sh    <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  r_sh    <= i_data;
                  r_cnt   <= '0;
                  r_state <= c_SHIFT;
               end
            end
            c_SHIFT: begin
               if (i_ce) begin
                  if (!w_at_last) begin
                     r_sh  <= w_sh_next;
                     r_cnt <= r_cnt + c_ONE;
                  end else if (w_accept) begin
                     r_sh  <= i_data;
                     r_cnt <= '0;
                  end else begin
                     r_state <= c_IDLE;
                  end
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // Line outputs come straight from registered state and are forced low in IDLE.
   always_comb begin
      o_ready     = w_ready;
      o_serial    = w_shifting & w_out_bit;
      o_bit_valid = w_shifting;
      o_first     = w_shifting & (r_cnt == '0);
      o_last      = w_shifting & w_at_last;
   end

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_shift_tx
// Description : Directed self-checking bench for piso_shift_tx (MSB-first and
//               LSB-first instances, WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_shift_tx;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;

   logic       i_ce_m = 1'b0, i_valid_m = 1'b0;
   logic [7:0] i_data_m = '0;
   logic       o_ready_m, o_serial_m, o_bit_valid_m, o_first_m, o_last_m;

   logic       i_ce_l = 1'b0, i_valid_l = 1'b0;
   logic [7:0] i_data_l = '0;
   logic       o_ready_l, o_serial_l, o_bit_valid_l, o_first_l, o_last_l;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
      .CLK(CLK), .RST(RST), .i_ce(i_ce_m), .i_data(i_data_m), .i_valid(i_valid_m),
      .o_ready(o_ready_m), .o_serial(o_serial_m), .o_bit_valid(o_bit_valid_m),
      .o_first(o_first_m), .o_last(o_last_m));

   piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
      .CLK(CLK), .RST(RST), .i_ce(i_ce_l), .i_data(i_data_l), .i_valid(i_valid_l),
      .o_ready(o_ready_l), .o_serial(o_serial_l), .o_bit_valid(o_bit_valid_l),
      .o_first(o_first_l), .o_last(o_last_l));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_idle_m(input string tag);
      chk({tag, ".bv"},    o_bit_valid_m, 0);
      chk({tag, ".ser"},   o_serial_m,    0);
      chk({tag, ".first"}, o_first_m,     0);
      chk({tag, ".last"},  o_last_m,      0);
      chk({tag, ".rdy"},   o_ready_m,     1);
   endtask

   // Checks one full MSB-first word with i_ce tied high; entered in cycle N+1.
   task automatic frame_m(input string tag, input logic [7:0] w);
      logic [7:0] wv;
      wv = w;
      for (int k = 0; k < 8; k++) begin
         chk({tag, ".ser"},   o_serial_m,    wv[7-k]);
         chk({tag, ".bv"},    o_bit_valid_m, 1);
         chk({tag, ".first"}, o_first_m,     (k == 0));
         chk({tag, ".last"},  o_last_m,      (k == 7));
         chk({tag, ".rdy"},   o_ready_m,     (k == 7));
         tick();
      end
   endtask

   initial begin
      logic [15:0] pair;
      logic [7:0]  wv;

      // Reset
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      chk_idle_m("reset");
      chk("reset.lsb.rdy", o_ready_l, 1);
      chk("reset.lsb.bv",  o_bit_valid_l, 0);

      // Single word A5, MSB first
      i_ce_m = 1'b1; i_valid_m = 1'b1; i_data_m = 8'hA5;
      tick();
      i_valid_m = 1'b0; i_data_m = 8'h00;
      frame_m("a5", 8'hA5);
      chk_idle_m("a5.after");

      // Back-to-back A5 then 3C with i_valid held
      pair = 16'hA53C;
      i_valid_m = 1'b1; i_data_m = 8'hA5;
      tick();
      i_data_m = 8'h3C;
      for (int k = 0; k < 16; k++) begin
         if (k == 8) i_valid_m = 1'b0;
         chk("b2b.ser",   o_serial_m,    pair[15-k]);
         chk("b2b.bv",    o_bit_valid_m, 1);
         chk("b2b.first", o_first_m,     (k == 0 || k == 8));
         chk("b2b.last",  o_last_m,      (k == 7 || k == 15));
         chk("b2b.rdy",   o_ready_m,     (k == 7 || k == 15));
         tick();
      end
      chk_idle_m("b2b.after");

      // Strobe every third cycle, word F0
      wv = 8'hF0;
      i_valid_m = 1'b1; i_data_m = wv; i_ce_m = 1'b0;
      tick();
      i_valid_m = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         i_ce_m = ((c % 3) == 0);
         #1;
         chk("strobe.ser",   o_serial_m,  wv[7 - (c-1)/3]);
         chk("strobe.rdy",   o_ready_m,   (c == 24));
         chk("strobe.first", o_first_m,   (c <= 3));
         chk("strobe.last",  o_last_m,    (c >= 22));
         tick();
      end
      i_ce_m = 1'b1;
      chk_idle_m("strobe.after");

      // Mid-frame i_valid pulse with FF is ignored and never sent
      wv = 8'h96;
      i_valid_m = 1'b1; i_data_m = wv;
      tick();
      i_valid_m = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == 2) begin i_valid_m = 1'b1; i_data_m = 8'hFF; end
         else        begin i_valid_m = 1'b0; i_data_m = 8'h00; end
         #1;
         chk("ign.ser", o_serial_m, wv[7-k]);
         chk("ign.rdy", o_ready_m,  (k == 7));
         tick();
      end
      i_valid_m = 1'b0;
      chk_idle_m("ign.after");
      tick();
      chk_idle_m("ign.notsent");

      // Reset in cycle N+4 aborts the frame, then a clean word follows
      wv = 8'hC3;
      i_valid_m = 1'b1; i_data_m = wv;
      tick();
      i_valid_m = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("abort.ser", o_serial_m, wv[7-k]);
         tick();
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk_idle_m("abort.rst");
      i_valid_m = 1'b1; i_data_m = 8'h5A;
      tick();
      i_valid_m = 1'b0;
      frame_m("abort.next", 8'h5A);
      chk_idle_m("abort.next.after");

      // LSB-first instance: 01 then B4
      i_ce_l = 1'b1; i_valid_l = 1'b1; i_data_l = 8'h01;
      tick();
      i_valid_l = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("lsb01.ser",   o_serial_l, (k == 0));
         chk("lsb01.first", o_first_l,  (k == 0));
         chk("lsb01.last",  o_last_l,   (k == 7));
         tick();
      end
      chk("lsb01.bv_after", o_bit_valid_l, 0);
      wv = 8'hB4;
      i_valid_l = 1'b1; i_data_l = wv;
      tick();
      i_valid_l = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("lsbb4.ser", o_serial_l,    wv[k]);
         chk("lsbb4.bv",  o_bit_valid_l, 1);
         tick();
      end
      chk("lsbb4.bv_after", o_bit_valid_l, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in, serial-out shift transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per bit-strobe on a single serial line, with first/last bit markers. It is the transmit end of the serial shift-chain path: it produces the bitstream that the flip-flop delay and deserialising chains consume. A bit-rate strobe allows the same block to drive slow serial links, and back-to-back words stream with no gap.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 transmitted first.

- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset; synchronous and active-high.
- i_ce  input  1  bit strobe; the current bit advances only in cycles where i_ce=1.
- i_data  input  WIDTH  parallel word; sampled only on an accepted handshake.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  block accepts i_data this cycle (combinational).
- o_serial  output  1  current serial bit (registered).
- o_bit_valid  output  1  o_serial carries a frame bit.
- o_first  output  1  o_serial is the first bit of a word.
- o_last  output  1  o_serial is the last bit of a word.

## Operation
- State: a WIDTH-bit shift register (sh), a bit counter (cnt, $clog2(WIDTH) bits, range 0..WIDTH-1), and a state machine with states IDLE and SHIFT.
- Accept: accept = i_valid & o_ready.
- o_ready = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1 & i_ce).
- IDLE, on accept: sh <= i_data, cnt <= 0, go to SHIFT.
- IDLE, without accept: hold state.
- SHIFT, i_ce=0: hold sh and cnt; the current bit stays on the line.
- SHIFT, i_ce=1, cnt<WIDTH-1: shift sh toward the output end and increment cnt. With MSB_FIRST=1, sh <= {sh[WIDTH-2:0],1'b0}; with MSB_FIRST=0, sh <= {1'b0,sh[WIDTH-1:1]}.
- SHIFT, i_ce=1, cnt==WIDTH-1:
  - if accept: reload sh with the new word, set cnt <= 0, stay in SHIFT. This is back-to-back streaming with no idle bit.
  - otherwise: go to IDLE.
- Outputs in SHIFT:
  - o_serial = sh[WIDTH-1] (MSB_FIRST=1) or sh[0] (MSB_FIRST=0).
  - o_bit_valid = 1.
  - o_first = (cnt==0).
  - o_last = (cnt==WIDTH-1).
- Outputs in IDLE: o_serial, o_bit_valid, o_first and o_last are all 0.
- Ignored inputs: i_data and i_valid are ignored whenever o_ready=0. A held i_valid is accepted at the next o_ready cycle.
- i_ce in IDLE has no effect. A word is accepted in IDLE regardless of i_ce.

## Timing
- Reset values: state=IDLE, sh=0, cnt=0. Outputs after reset: o_serial=0, o_bit_valid=0, o_first=0, o_last=0, o_ready=1.
- RST takes priority over every other input, including mid-frame. The frame is aborted with no partial completion, and the IDLE outputs above appear after the reset edge.
- Latency: for a word accepted on edge N (from IDLE), the first bit appears after edge N, i.e. in cycle N+1.
- Bit duration: bit k is on the line from its presentation until the end of the first cycle with i_ce=1. With i_ce tied high, each bit lasts exactly one cycle, and a word occupies cycles N+1..N+WIDTH.
- Back-to-back: accepting during the last-bit strobe cycle puts the next word's first bit in the very next cycle.
- Simultaneous events:
  - i_valid high while SHIFT with cnt<WIDTH-1: no accept, no effect.
  - i_valid high in the last-bit cycle with i_ce=0: no accept.
- o_ready depends combinationally on i_ce only in SHIFT. There is no combinational path from i_valid to o_ready.

## Test plan
- Reset, then one word, WIDTH=8, MSB_FIRST=1, i_ce=1, 8'hA5 accepted on edge N:
  - o_serial = 1,0,1,0,0,1,0,1 in cycles N+1..N+8.
  - o_first only in N+1; o_last only in N+8.
  - o_ready = 0 in N+1..N+7 and 1 in N+8.
  - o_bit_valid = 0 from N+9.
- Back-to-back, i_valid held high with 8'hA5 then 8'h3C:
  - 16 contiguous bits 1010_0101_0011_1100.
  - o_first in cycles N+1 and N+9; o_last in N+8 and N+16.
  - No idle cycle between words.
- Strobe: i_ce=1 only on cycles N+3, N+6, ..., word 8'hF0:
  - bit0 (1) held N+1..N+3, bit1 held N+4..N+6, ..., bit7 (0) held N+22..N+24.
  - o_ready asserted only in N+24.
- MSB_FIRST=0, word 8'h01, i_ce=1: o_serial = 1 then seven 0s; o_first coincides with the 1.
- Abort and ignore:
  - RST asserted in cycle N+4 of a frame: all outputs 0 and o_ready=1 after that edge, and the next accepted word starts cleanly.
  - i_valid pulsed with 8'hFF in N+3 (mid-frame): no effect on the bitstream, and the word is not sent.
